mmio_responder: RTL

Memory-mapped I/O responder on the CPU data-bus side: it answers the CPU's load/store requests in a fixed address window, next to data memory. It holds switch/button input conditioning (synchronise plus debounce), an LED output register, a sticky button-press flag with clear-on-read, and a free-running cycle timer. The top level muxes `dout` into the load path whenever `hit` is high.

---
 rtl/mmio_responder_pkg.sv | 33 +++
 rtl/mmio_responder_io_debouncer.sv | 61 ++++++
 rtl/mmio_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared constants and the register-select decoder for the MMIO responder.
package mmio_responder_pkg;

  localparam int          REGWIDTH    = 32;
  localparam int          IO_WIN_BITS = 6;
  localparam logic [31:0] IO_BASE     = 32'hFFFF_FC00;
  localparam logic [5:0]  IO_SW       = 6'h00;
  localparam logic [5:0]  IO_LED      = 6'h04;
  localparam logic [5:0]  IO_BTN      = 6'h08;
  localparam logic [5:0]  IO_TIMER    = 6'h0C;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_SW    = 3'd1,
    SEL_LED   = 3'd2,
    SEL_BTN   = 3'd3,
    SEL_TIMER = 3'd4
  } io_sel_e;

  // Word-granular decode: the two byte-lane bits never take part.
  function automatic io_sel_e decode_sel(input logic [IO_WIN_BITS-1:0] off);
    io_sel_e sel;
    case (off[IO_WIN_BITS-1:2])
      IO_SW[IO_WIN_BITS-1:2]:    sel = SEL_SW;
      IO_LED[IO_WIN_BITS-1:2]:   sel = SEL_LED;
      IO_BTN[IO_WIN_BITS-1:2]:   sel = SEL_BTN;
      IO_TIMER[IO_WIN_BITS-1:2]: sel = SEL_TIMER;
      default:                   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_responder_io_debouncer.sv
// Two-flop synchroniser followed by a shared-count debouncer for a bus of raw inputs.
module io_debouncer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise
);

  localparam int             CW       = $clog2(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // Next-state: any difference between synced and stable keeps the common count running.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = {CW{1'b0}};
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = {CW{1'b0}};
        accept   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= {WIDTH{1'b0}};
      sync2_q  <= {WIDTH{1'b0}};
      stable_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  // Rise flags the edge at which a bit of stable is about to go 0 -> 1.
  assign rise   = accept ? (sync2_q & ~stable_q) : {WIDTH{1'b0}};

endmodule

// File: rtl/mmio_responder.sv
// CPU-side MMIO responder: debounced switches/button, LED register, sticky press flag, cycle timer.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = IO_BASE,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         switches,
  input  logic                button,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [REGWIDTH-1:0] addr,
  input  logic [REGWIDTH-1:0] din,
  output logic [REGWIDTH-1:0] dout,
  output logic                hit,
  output logic [15:0]         LED
);

  logic [15:0]         sw_db, sw_rise;
  logic [0:0]          btn_db, btn_rise;
  logic [15:0]         led_q, led_d;
  logic [REGWIDTH-1:0] timer_q, timer_d;
  logic                press_flag_q, press_flag_d;
  logic [7:0]          press_cnt_q, press_cnt_d;
  io_sel_e             sel;
  logic                rd_en, wr_en;
  logic                unused_bits;

  io_debouncer #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (switches),
    .stable (sw_db),
    .rise   (sw_rise)
  );

  io_debouncer #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (button),
    .stable (btn_db),
    .rise   (btn_rise)
  );

  assign unused_bits = ^{addr[1:0], sw_rise, btn_db};

  // Address decode and zero-latency load mux.
  always_comb begin
    hit   = (addr[REGWIDTH-1:IO_WIN_BITS] == BASE_ADDR[REGWIDTH-1:IO_WIN_BITS]);
    sel   = decode_sel(addr[IO_WIN_BITS-1:0]);
    rd_en = MemRead & hit;
    wr_en = MemWrite & hit;
    dout  = {REGWIDTH{1'b0}};
    if (rd_en) begin
      case (sel)
        SEL_SW:    dout = {16'h0000, sw_db};
        SEL_LED:   dout = {16'h0000, led_q};
        SEL_BTN:   dout = {16'h0000, press_cnt_q, 7'b000_0000, press_flag_q};
        SEL_TIMER: dout = timer_q;
        default:   dout = {REGWIDTH{1'b0}};
      endcase
    end else begin
      dout = {REGWIDTH{1'b0}};
    end
  end

  // Register next-state; a debounced press beats a concurrent clear-on-read.
  always_comb begin
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    press_flag_d = press_flag_q;
    press_cnt_d  = press_cnt_q;
    if (wr_en && (sel == SEL_LED)) begin
      led_d = din[15:0];
    end else begin
      led_d = led_q;
    end
    if (wr_en && (sel == SEL_TIMER)) begin
      timer_d = din;
    end else begin
      timer_d = timer_q + 32'd1;
    end
    if (btn_rise[0]) begin
      press_flag_d = 1'b1;
      press_cnt_d  = press_cnt_q + 8'd1;
    end else if (rd_en && (sel == SEL_BTN)) begin
      press_flag_d = 1'b0;
      press_cnt_d  = press_cnt_q;
    end else begin
      press_flag_d = press_flag_q;
      press_cnt_d  = press_cnt_q;
    end
  end

  // Architectural registers; reset overrides any concurrent access.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q        <= 16'h0000;
      timer_q      <= 32'h0000_0000;
      press_flag_q <= 1'b0;
      press_cnt_q  <= 8'h00;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      press_flag_q <= press_flag_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign LED = led_q;

endmodule
